seq_shifter: RTL and testbench



---
 rtl/seq_shifter_if.sv | 25 ++
 rtl/seq_shifter.sv | 129 ++++++++++++
 tb/tb_seq_shifter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: operand capture on start, result
// held on out/carry_out and qualified by a one-cycle done pulse.
interface seq_shifter_if #(
    parameter int WIDTH = 64,
    parameter int AMT_W = 6
);
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amt;
    logic [WIDTH-1:0] in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             carry_out;

    modport master (
        output start, mode, amt, in,
        input  busy, done, out, carry_out
    );

    modport slave (
        input  start, mode, amt, in,
        output busy, done, out, carry_out
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle LSL/LSR/ASR/ROR shifter: moves at most STEP bit positions per
// clock and reports the last bit shifted out as the shifter carry.
module seq_shifter #(
    parameter int WIDTH = 64,
    parameter int AMT_W = 6,
    parameter int STEP  = 8
) (
    input  logic         clk,
    input  logic         reset,
    seq_shifter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } mode_e;

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_out_q, carry_out_d;

    logic [AMT_W-1:0] k;
    logic [WIDTH-1:0] shifted;
    logic             step_carry;

    // One step of at most STEP positions: a STEP-way mux of fixed shifts.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        k          = (int'(rem_q) < STEP) ? rem_q : AMT_W'(STEP);
        shifted    = data_q;
        step_carry = carry_q;
        for (int i = 1; i <= STEP; i++) begin
            if (int'(k) == i) begin
                case (mode_q)
                    LSL: begin
                        shifted    = data_q << i;
                        step_carry = data_q[WIDTH-i];
                    end
                    LSR: begin
                        shifted    = data_q >> i;
                        step_carry = data_q[i-1];
                    end
                    ASR: begin
                        shifted    = $unsigned($signed(data_q) >>> i);
                        step_carry = data_q[i-1];
                    end
                    ROR: begin
                        shifted    = (data_q >> i) | (data_q << (WIDTH - i));
                        step_carry = data_q[i-1];  // lands in the MSB after rotating
                    end
                endcase
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        data_d      = data_q;
        rem_d       = rem_q;
        carry_d     = carry_q;
        out_d       = out_q;
        carry_out_d = carry_out_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bus.in;
                    mode_d  = mode_e'(bus.mode);
                    rem_d   = bus.amt;
                    carry_d = 1'b0;
                    state_d = (bus.amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_d  = shifted;
                carry_d = step_carry;
                rem_d   = rem_q - k;
                if (rem_d == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Result registers load only on the edge that enters DONE.
        if (state_d == DONE) begin
            out_d       = data_d;
            carry_out_d = carry_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            out_q       <= '0;
            carry_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            carry_out_q <= carry_out_d;
        end
    end

    // NOTE: working registers are left unreset; they are always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        mode_q  <= mode_d;
        data_q  <= data_d;
        rem_q   <= rem_d;
        carry_q <= carry_d;
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.carry_out = carry_out_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: per-mode results, carry, done latency,
// ignored start while busy, and reset abandoning an operation.
module tb_seq_shifter;

    localparam int WIDTH = 64;
    localparam int AMT_W = 6;
    localparam logic [1:0] M_LSL = 2'b00;
    localparam logic [1:0] M_LSR = 2'b01;
    localparam logic [1:0] M_ASR = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    logic clk = 1'b0;
    logic reset;

    seq_shifter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

    seq_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STEP(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it to done; cycles counts edges from the accepting edge.
    task automatic run_op(input string tag, input logic [1:0] mode, input logic [AMT_W-1:0] amt,
                          input logic [WIDTH-1:0] in, input logic [WIDTH-1:0] exp_out,
                          input logic exp_carry, input int exp_cycles);
        int   cycles;
        logic busy_ok;
        bus.mode  = mode;
        bus.amt   = amt;
        bus.in    = in;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cycles  = 1;
        busy_ok = 1'b1;
        while (!bus.done && cycles < 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            cycles++;
        end
        check({tag, "_latency"}, 64'(cycles), 64'(exp_cycles));
        check({tag, "_busy_during"}, 64'(busy_ok && bus.busy), 64'(1));
        check({tag, "_out"}, bus.out, exp_out);
        check({tag, "_carry"}, 64'(bus.carry_out), 64'(exp_carry));
        tick();
        check({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
        check({tag, "_idle_after"}, 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_done;
        int   first_done;
        logic [WIDTH-1:0] out_at_done;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = M_LSL;
        bus.amt   = '0;
        bus.in    = '0;
        tick();
        tick();
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_out", bus.out, 64'(0));
        check("rst_carry", 64'(bus.carry_out), 64'(0));

        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        bus.amt   = 6'd5;
        bus.in    = 64'hFF;
        tick();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("rst_vs_start_busy", 64'(bus.busy), 64'(0));
        tick();
        check("rst_vs_start_done", 64'(bus.done), 64'(0));

        run_op("lsl_6x2", M_LSL, 6'd2, 64'd6, 64'd24, 1'b0, 2);
        run_op("lsl_carry", M_LSL, 6'd2, 64'hC000_0000_0000_0000, 64'd0, 1'b1, 2);
        run_op("lsr_1", M_LSR, 6'd1, 64'h8000_0000_0000_0001, 64'h4000_0000_0000_0000, 1'b1, 2);
        run_op("lsr_12", M_LSR, 6'd12, 64'h0F00, 64'd0, 1'b1, 3);
        run_op("asr_63", M_ASR, 6'd63, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 9);
        run_op("ror_20", M_ROR, 6'd20, 64'd1, 64'h0000_1000_0000_0000, 1'b0, 4);
        for (int m = 0; m < 4; m++) begin
            run_op($sformatf("amt0_m%0d", m), 2'(m), 6'd0, 64'h1234, 64'h1234, 1'b0, 1);
        end

        // Second start while busy must be ignored and not queued.
        bus.mode  = M_ROR;
        bus.amt   = 6'd20;
        bus.in    = 64'd1;
        bus.start = 1'b1;
        tick();
        bus.start   = 1'b0;
        n_done      = 0;
        first_done  = 0;
        out_at_done = '0;
        for (int c = 1; c <= 12; c++) begin
            if (bus.done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done  = c;
                    out_at_done = bus.out;
                end
            end
            if (c == 2) begin
                bus.mode  = M_LSL;
                bus.amt   = 6'd1;
                bus.in    = 64'hFF;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            tick();
        end
        check("ign_start_ndone", 64'(n_done), 64'(1));
        check("ign_start_latency", 64'(first_done), 64'(4));
        check("ign_start_out", out_at_done, 64'h0000_1000_0000_0000);
        check("ign_start_out_held", bus.out, 64'h0000_1000_0000_0000);
        check("ign_start_idle", 64'(bus.busy), 64'(0));

        run_op("ror_1", M_ROR, 6'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 2);

        // Reset in the middle of a long LSL abandons it.
        bus.mode  = M_LSL;
        bus.amt   = 6'd40;
        bus.in    = 64'h1234;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("mid_busy", 64'(bus.busy), 64'(1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_busy", 64'(bus.busy), 64'(0));
        check("mid_rst_done", 64'(bus.done), 64'(0));
        check("mid_rst_out", bus.out, 64'(0));
        check("mid_rst_carry", 64'(bus.carry_out), 64'(0));
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus.done) n_done++;
            tick();
        end
        check("mid_rst_no_done", 64'(n_done), 64'(0));

        run_op("lsl_40", M_LSL, 6'd40, 64'h1234, 64'h0012_3400_0000_0000, 1'b0, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
